// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter: IF/DM arbiter and sequencer for a single-port fixed-latency memory.
// rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mem_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int LAT    = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  input  logic              dm_rd,
  input  logic              dm_wr,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_ready,
  output logic              stall,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int               CNT_W    = $clog2(LAT + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LAT);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic             owner_dm;
  logic             last_dm;

  logic dm_req;
  logic any_req;
  logic grant_dm;
  logic wait_last;

  assign dm_req    = dm_rd | dm_wr;
  assign any_req   = if_req | dm_req;
  // Data wins, except right after a data grant when fetch is waiting.
  assign grant_dm  = dm_req & ~(last_dm & if_req);
  assign wait_last = (cnt == CNT_ONE);
  assign stall     = (if_req & ~if_ready) | (dm_req & ~dm_ready);

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (any_req) state_next = ISSUE;
      ISSUE:   state_next = WAIT;
      WAIT:    if (wait_last) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      owner_dm  <= 1'b0;
      last_dm   <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_ready  <= 1'b0;
      dm_ready  <= 1'b0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
    end else begin
      state    <= state_next;
      mem_en   <= 1'b0;
      if_ready <= 1'b0;
      dm_ready <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            mem_en   <= 1'b1;
            owner_dm <= grant_dm;
            last_dm  <= grant_dm;
            mem_we   <= grant_dm & dm_wr;
            mem_addr <= grant_dm ? dm_addr : if_addr;
            if (grant_dm) mem_wdata <= dm_wdata;
          end
        end
        ISSUE: cnt <= CNT_LOAD;
        WAIT: begin
          cnt <= cnt - CNT_ONE;
          if (wait_last) begin
            // mem_we still holds the latched write flag of this access.
            if (!mem_we) begin
              if (owner_dm) dm_rdata <= mem_rdata;
              else          if_rdata <= mem_rdata;
            end
            if (owner_dm) dm_ready <= 1'b1;
            else          if_ready <= 1'b1;
          end
        end
        DONE:    ;
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter: randomized scoreboard bench for mem_arbiter (LAT=2 and LAT=1).
// rev 1.0
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_mem_arbiter;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;
  localparam int LAT    = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        if_req = 1'b0;
  logic [15:0] if_addr = '0;
  logic [15:0] if_rdata;
  logic        if_ready;
  logic        dm_rd = 1'b0;
  logic        dm_wr = 1'b0;
  logic [15:0] dm_addr = '0;
  logic [15:0] dm_wdata = '0;
  logic [15:0] dm_rdata;
  logic        dm_ready;
  logic        stall;
  logic        mem_en;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata = '0;

  logic        if_req1 = 1'b0;
  logic [15:0] if_addr1 = '0;
  logic [15:0] if_rdata1;
  logic        if_ready1;
  logic        dm_zero = 1'b0;
  logic [15:0] dm_zero16 = '0;
  logic [15:0] dm_rdata1;
  logic        dm_ready1;
  logic        stall1;
  logic        mem_en1;
  logic        mem_we1;
  logic [15:0] mem_addr1;
  logic [15:0] mem_wdata1;
  logic [15:0] mem_rdata1 = '0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LAT(LAT)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .dm_rd(dm_rd), .dm_wr(dm_wr), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_ready(dm_ready), .stall(stall),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LAT(1)) dut1 (
    .clk(clk), .reset(reset),
    .if_req(if_req1), .if_addr(if_addr1), .if_rdata(if_rdata1), .if_ready(if_ready1),
    .dm_rd(dm_zero), .dm_wr(dm_zero), .dm_addr(dm_zero16), .dm_wdata(dm_zero16),
    .dm_rdata(dm_rdata1), .dm_ready(dm_ready1), .stall(stall1),
    .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1),
    .mem_wdata(mem_wdata1), .mem_rdata(mem_rdata1)
  );

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Contents of never-written memory locations.
  function automatic logic [15:0] init_val(input logic [15:0] a);
    return a ^ 16'h5A3C ^ {a[7:0], a[15:8]};
  endfunction

  // Memory device: writes land immediately, reads return after LAT cycles,
  // and the read bus carries noise in every other cycle.
  typedef struct { int due; logic [15:0] data; } rsp_t;
  rsp_t        rsp_q[$];
  rsp_t        rsp_new;
  logic [15:0] mem_store [logic [15:0]];

  function automatic logic [15:0] rd_mem(input logic [15:0] a);
    return mem_store.exists(a) ? mem_store[a] : init_val(a);
  endfunction

  always @(negedge clk) begin
    if (rsp_q.size() > 0 && rsp_q[0].due == cyc) begin
      mem_rdata = rsp_q[0].data;
      void'(rsp_q.pop_front());
    end else begin
      mem_rdata = 16'($urandom);
    end
    if (reset) rsp_q.delete();
    else if (mem_en) begin
      if (mem_we) mem_store[mem_addr] = mem_wdata;
      else begin
        rsp_new.due  = cyc + LAT;
        rsp_new.data = rd_mem(mem_addr);
        rsp_q.push_back(rsp_new);
      end
    end
  end

  logic mem_en1_prev = 1'b0;
  always @(negedge clk) begin
    mem_rdata1   = mem_en1_prev ? init_val(mem_addr1) : 16'($urandom);
    mem_en1_prev = mem_en1;
  end

  // Scoreboard queues filled by the requesters.
  typedef struct { logic is_rd; logic [15:0] data; } dexp_t;
  logic [15:0] if_exp_q[$];
  dexp_t       dm_exp_q[$];
  dexp_t       dexp;
  logic [15:0] dm_shadow [logic [15:0]];
  logic [15:0] dm_rdata_m = '0;

  // Arbitration and timing reference: one access at a time, command one cycle
  // after the IDLE sample, ready LAT+2 cycles after it.
  logic        model_free = 1'b1;
  logic        last_dm_m = 1'b0;
  logic        own_dm = 1'b0;
  logic        rst_seen = 1'b0;
  int          cmd_cyc = -1;
  int          rdy_cyc = -1;
  logic        c_we = 1'b0;
  logic [15:0] c_addr = '0;
  logic [15:0] c_wdata = '0;

  always @(negedge clk) begin
    logic dmr;
    logic if_rdy_m;
    logic dm_rdy_m;
    logic [15:0] ie;
    if (rst_seen) begin
      chk("reset_ctrl", {28'd0, mem_en, mem_we, if_ready, dm_ready, mem_addr, mem_wdata}, 64'd0);
      chk("reset_rdata", {32'd0, if_rdata, dm_rdata}, 64'd0);
    end
    if (reset) begin
      rst_seen   = 1'b1;
      model_free = 1'b1;
      last_dm_m  = 1'b0;
      cmd_cyc    = -1;
      rdy_cyc    = -1;
      dm_rdata_m = '0;
      if_exp_q.delete();
      dm_exp_q.delete();
    end else begin
      rst_seen = 1'b0;
      dmr      = dm_rd | dm_wr;
      if_rdy_m = (cyc == rdy_cyc) && !own_dm;
      dm_rdy_m = (cyc == rdy_cyc) && own_dm;
      chk("stall", stall, (if_req & ~if_rdy_m) | (dmr & ~dm_rdy_m));
      chk("mem_en", mem_en, cyc == cmd_cyc);
      if (cyc == cmd_cyc) begin
        chk("mem_addr", mem_addr, c_addr);
        chk("mem_we", mem_we, c_we);
        if (c_we) chk("mem_wdata", mem_wdata, c_wdata);
      end
      chk("if_ready", if_ready, if_rdy_m);
      chk("dm_ready", dm_ready, dm_rdy_m);
      if (if_ready) begin
        if (if_exp_q.size() == 0) chk("if_unexpected", 1, 0);
        else begin
          ie = if_exp_q.pop_front();
          chk("if_rdata", if_rdata, ie);
        end
      end
      if (dm_ready) begin
        if (dm_exp_q.size() == 0) chk("dm_unexpected", 1, 0);
        else begin
          dexp = dm_exp_q.pop_front();
          chk(dexp.is_rd ? "dm_rdata_read" : "dm_rdata_hold", dm_rdata, dexp.data);
        end
      end
      if (model_free && (if_req || dmr)) begin
        own_dm     = dmr && !(last_dm_m && if_req);
        last_dm_m  = own_dm;
        c_we       = own_dm && dm_wr;
        c_addr     = own_dm ? dm_addr : if_addr;
        c_wdata    = dm_wdata;
        cmd_cyc    = cyc + 1;
        rdy_cyc    = cyc + LAT + 2;
        model_free = 1'b0;
      end
      if (cyc == rdy_cyc) model_free = 1'b1;
    end
  end

  // Requesters change inputs 1 ns after the rising edge.
  task automatic if_txn(input logic [15:0] a);
    int n;
    if_addr = a;
    if_req  = 1'b1;
    if_exp_q.push_back(init_val(a));
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!if_ready && n < 200);
    if (!if_ready) chk("if_timeout", 0, 1);
    if_req  = 1'b0;
    if_addr = 16'($urandom);
  endtask

  task automatic dm_txn(input int op, input logic [15:0] a, input logic [15:0] d);
    int n;
    dexp_t e;
    dm_addr  = a;
    dm_wdata = d;
    dm_rd    = (op != 1);
    dm_wr    = (op != 0);
    if (op == 0) begin
      e.is_rd    = 1'b1;
      e.data     = dm_shadow.exists(a) ? dm_shadow[a] : init_val(a);
      dm_rdata_m = e.data;
    end else begin
      dm_shadow[a] = d;
      e.is_rd      = 1'b0;
      e.data       = dm_rdata_m;
    end
    dm_exp_q.push_back(e);
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!dm_ready && n < 200);
    if (!dm_ready) chk("dm_timeout", 0, 1);
    dm_rd    = 1'b0;
    dm_wr    = 1'b0;
    dm_wdata = 16'($urandom);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    fork
      begin
        for (int i = 0; i < 40; i++) begin
          repeat ($urandom_range(0, 3)) @(posedge clk);
          #0 if_txn(16'($urandom) & 16'h7FFF);
        end
      end
      begin
        for (int j = 0; j < 40; j++) begin
          repeat ($urandom_range(0, 2)) @(posedge clk);
          #0 dm_txn(int'($urandom_range(0, 2)), 16'h8000 | 16'($urandom_range(0, 7)),
                    16'($urandom));
        end
      end
    join
    repeat (4) @(posedge clk);
    #1;
    chk("if_queue_drained", if_exp_q.size(), 0);
    chk("dm_queue_drained", dm_exp_q.size(), 0);

    // Reset during the first WAIT cycle abandons the fetch without a ready pulse.
    if_addr = 16'h0123;
    if_req  = 1'b1;
    if_exp_q.push_back(init_val(16'h0123));
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!mem_en && n < 20);
    chk("rst_test_issue", mem_en, 1);
    @(posedge clk); #1;
    reset  = 1'b1;
    if_req = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    if_txn(16'h0010);
    dm_txn(1, 16'h8040, 16'h1234);
    dm_txn(2, 16'h8041, 16'hBEEF);
    dm_txn(0, 16'h8041, 16'h0000);
    repeat (3) @(posedge clk);
    #1;

    // LAT=1 instance: request-to-ready is three cycles.
    if_addr1 = 16'h0010;
    if_req1  = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!if_ready1 && n < 20);
    chk("lat1_latency", n, 3);
    chk("lat1_rdata", if_rdata1, init_val(16'h0010));
    if_req1 = 1'b0;
    @(posedge clk); #1;
    chk("lat1_pulse", if_ready1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_arbiter.md
# mem_arbiter

Arbiter and sequencer for a single-port, fixed-latency unified memory shared between the instruction-fetch stage and the data-memory stage of the 16-bit pipelined CPU. It accepts held-level requests from both ports and issues one memory command at a time. It returns read data with a one-cycle ready pulse, and raises a pipeline stall while any request is outstanding. Data accesses have priority; a fairness rule prevents fetch starvation.

## Interface
Parameters:
- ADDR_W, 16, address width
- DATA_W, 16, data width
- LAT, 2, memory read latency in cycles from command to data valid; legal values ≥1

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- if_req  in  1  fetch request, held until if_ready
- if_addr  in  ADDR_W  fetch address
- if_rdata  out  DATA_W  fetched instruction, valid while if_ready=1
- if_ready  out  1  one-cycle completion pulse for fetch
- dm_rd  in  1  data read request, held until dm_ready
- dm_wr  in  1  data write request, held until dm_ready
- dm_addr  in  ADDR_W  data address
- dm_wdata  in  DATA_W  write data
- dm_rdata  out  DATA_W  read data, valid while dm_ready=1
- dm_ready  out  1  one-cycle completion pulse for data access
- stall  out  1  pipeline freeze
- mem_en  out  1  memory command strobe
- mem_we  out  1  write enable, qualified by mem_en
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid LAT cycles after the mem_en cycle

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE. Reset → IDLE.
- IDLE: if no request is pending, stay in IDLE. Otherwise select a grant, latch the address, write data, write flag and grant owner, then → ISSUE.
- Grant rule: a DM request wins over an IF request. Exception: if the previous grant was DM and if_req=1, IF wins. Track this with a one-bit last_dm flag, reset to 0.
- dm_rd and dm_wr both high: treated as a write; the read is ignored.
- ISSUE (1 cycle): mem_en=1, with mem_we, mem_addr and mem_wdata driven from the latched values. Load the wait counter with LAT, then → WAIT.
- WAIT (exactly LAT cycles): decrement the counter. In the final WAIT cycle, capture mem_rdata into the owner's rdata register for reads; writes capture nothing. Then → DONE.
- DONE (1 cycle): pulse the owner's ready signal, then → IDLE unconditionally. The requester must drop or change its request by the next edge.
- rdata registers hold their last captured value until overwritten. A write leaves dm_rdata unchanged.
- stall = (if_req & ~if_ready) | ((dm_rd|dm_wr) & ~dm_ready). This is combinational.
- Request inputs are sampled only in IDLE. Address or data changes after the grant have no effect on the access in flight.
- Wait counter width: clog2(LAT+1).

## Timing
- Reset values: if_ready=0, dm_ready=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, if_rdata=0, dm_rdata=0, last_dm=0, state=IDLE.
- All outputs except stall are registered.
- If a request is seen in IDLE in cycle T: ISSUE is cycle T+1, WAIT is cycles T+2..T+1+LAT, DONE (ready=1) is cycle T+2+LAT, and IDLE is cycle T+3+LAT.
- Request-to-ready latency is LAT+2 cycles. Back-to-back throughput is one access per LAT+3 cycles.
- mem_en is high for exactly one cycle per access. No new command is issued before the previous one reaches DONE.
- Simultaneous IF and DM requests are resolved by the grant rule. The loser keeps stall=1 and is served on the next IDLE.
- Reset asserted mid-access (any state): on the next edge return to IDLE with all reset values. The in-flight memory response is discarded and no ready pulse is produced.
- A request deasserted before its ready pulse is abandoned by the requester. The arbiter still completes the access and pulses ready.

## Test plan
- Single fetch, LAT=2: if_req=1, if_addr=0x0010, mem returns 0xA5A5. Required: mem_en in cycle T+1 with mem_addr=0x0010 and mem_we=0; if_ready=1 and if_rdata=0xA5A5 in T+4; stall=1 during T..T+3 and 0 in T+4.
- Data write: dm_wr=1, dm_addr=0x0040, dm_wdata=0x1234. Required: mem_en=1, mem_we=1, mem_addr=0x0040 and mem_wdata=0x1234 in T+1; dm_ready in T+4; dm_rdata unchanged.
- Simultaneous requests: if_req=1 and dm_rd=1 from the same cycle, last_dm=0. Required: DM served first (dm_ready at T+4). IF is granted next because last_dm=1, even if a new dm_rd is already pending; if_ready at T+9.
- rd+wr collision: dm_rd=1 and dm_wr=1. Required: mem_we=1 during ISSUE, no dm_rdata update.
- Reset mid-WAIT: assert reset for one cycle during WAIT. Required: IDLE and all-zero outputs next cycle, no ready pulse; a fresh if_req afterwards completes normally in LAT+2 cycles.
- LAT=1 parameterisation: a single read completes in 3 cycles and mem_rdata is captured in the single WAIT cycle.
